// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: display fetch priority, host writes in spare slots
module vram_arbiter #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int DATA_W      = 3,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);
  localparam int unsigned       FB_SIZE = FB_W * FB_H;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t            state, state_next;
  logic              p_tick_d;
  logic              rise;
  logic [1:0]        ph_q;
  logic [1:0]        ph;
  logic              vis;
  logic              rise_d1, rise_d2;
  logic [ADDR_W-1:0] row, col, disp_addr;
  logic              wr_in_range;
  logic              wr_slot;
  logic              load_rd, load_wr;

  // Rising edge of the pixel tick marks cycle R of each pixel period.
  assign rise = p_tick & ~p_tick_d;

  // Phase is 0 in the rise cycle itself and counts up to 3 in R+3.
  assign ph = rise ? 2'd0 : ph_q;

  // Framebuffer address of the scaled-down pixel being scanned.
  assign row       = ADDR_W'(pixel_y >> SCALE_SHIFT);
  assign col       = ADDR_W'(pixel_x >> SCALE_SHIFT);
  assign disp_addr = row * FB_W_A + col;

  assign wr_in_range = 32'(wr_addr) < FB_SIZE;

  // A write started now must finish before the next rise, so ph=3 is never used to start one.
  assign wr_slot = wr_req && (ph != 2'd3);

  // Tick edge detection, phase counter and per-period display flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_tick_d <= 1'b0;
      ph_q     <= 2'd0;
      vis      <= 1'b0;
      rise_d1  <= 1'b0;
      rise_d2  <= 1'b0;
    end else begin
      p_tick_d <= p_tick;
      ph_q     <= (ph == 2'd3) ? 2'd3 : ph + 2'd1;
      if (rise) begin
        vis <= video_on;
      end
      rise_d1 <= rise;
      rise_d2 <= rise_d1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: display read wins at an active rise, writes fill the remaining slots.
  always_comb begin
    state_next = state;
    load_rd    = 1'b0;
    load_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (rise && video_on) begin
          state_next = RD;
          load_rd    = 1'b1;
        end else if (wr_slot) begin
          state_next = WR;
          load_wr    = 1'b1;
        end
      end
      RD: begin
        state_next = CAP;
      end
      CAP: begin
        if (wr_slot) begin
          state_next = WR;
          load_wr    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      WR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered RAM port and write handshake; strobes last exactly the WR cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      if (load_rd) begin
        mem_addr <= disp_addr;
      end else if (load_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
        mem_we    <= wr_in_range;
        wr_ack    <= 1'b1;
        wr_err    <= ~wr_in_range;
      end
    end
  end

  // Pixel output three clocks after every rise; blanked periods output black.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= rise_d2;
      if (rise_d2) begin
        pix_data <= (vis && state == CAP) ? mem_rdata : '0;
      end
    end
  end

endmodule
